// File: rtl/leds_racer_pkg.sv
// Shared types for the LEDs racer: game phases, player indices and the position-width helper.
// Imported by racer_lane and race_sequencer.
package leds_racer_pkg;

    typedef enum logic [1:0] {
        PH_IDLE      = 2'd0,
        PH_COUNTDOWN = 2'd1,
        PH_RACE      = 2'd2,
        PH_WIN       = 2'd3
    } phase_e;

    localparam logic [1:0] GREEN  = 2'd0;
    localparam logic [1:0] RED    = 2'd1;
    localparam logic [1:0] BLUE   = 2'd2;
    localparam logic [1:0] YELLOW = 2'd3;

    function automatic int pos_width(input int max_pos);
        return (max_pos > 1) ? $clog2(max_pos) : 1;
    endfunction

endpackage

// File: rtl/racer_lane.sv
// One player lane: press edge detect and saturating position counter.
// With FALSE_START_PENALTY_EN defined it also keeps the false-start flag and applies the lockout.
module racer_lane #(
    parameter int MAX_POS = 109,
    parameter int POS_W   = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_i,
    input  logic             clear_i,
    input  logic             step_en_i,
`ifdef FALSE_START_PENALTY_EN
    input  logic             flag_set_i,
    input  logic             lock_i,
    input  logic             flag_clr_i,
`endif
    output logic             press_o,
    output logic             finish_o,
    output logic [POS_W-1:0] pos_o
);

    localparam logic [POS_W-1:0] LAST_POS = POS_W'(MAX_POS - 1);
    localparam logic [POS_W-1:0] PRE_LAST = POS_W'(MAX_POS - 2);

    logic             btn_prev_q;
    logic [POS_W-1:0] pos_q;
    logic [POS_W-1:0] pos_d;
    logic             step;

    // History resets high so a button held through reset is not taken as a press.
    assign press_o = btn_i & ~btn_prev_q;

`ifdef FALSE_START_PENALTY_EN
    logic flag_q;

    assign step = press_o & step_en_i & ~(flag_q & lock_i);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag_q <= 1'b0;
        end else if (flag_clr_i) begin
            flag_q <= 1'b0;
        end else if (flag_set_i && press_o) begin
            flag_q <= 1'b1;
        end
    end
`else
    assign step = press_o & step_en_i;
`endif

    always_comb begin
        pos_d = pos_q;
        if (clear_i) begin
            pos_d = '0;
        end else if (step && (pos_q != LAST_POS)) begin
            pos_d = pos_q + 1'b1;
        end
    end

    assign finish_o = step && (pos_q == PRE_LAST);
    assign pos_o    = pos_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_prev_q <= 1'b1;
            pos_q      <= '0;
        end else begin
            btn_prev_q <= btn_i;
            pos_q      <= pos_d;
        end
    end

endmodule

// File: rtl/race_sequencer.sv
// Game-phase controller: IDLE -> COUNTDOWN -> RACE -> WIN, paced by update_frame ticks.
// Optional false-start lockout is enabled by defining FALSE_START_PENALTY_EN.
module race_sequencer
    import leds_racer_pkg::*;
#(
    parameter int MAX_POS           = 109,
    parameter int COUNT_STEP_FRAMES = 30,
    parameter int WIN_HOLD_FRAMES   = 150,
    parameter int PENALTY_FRAMES    = 60,
    localparam int POS_W            = pos_width(MAX_POS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             update_frame,
    input  logic             btn_green,
    input  logic             btn_red,
    input  logic             btn_blue,
    input  logic             btn_yellow,
    output logic [1:0]       phase,
    output logic [1:0]       countdown,
    output logic [POS_W-1:0] pos_green,
    output logic [POS_W-1:0] pos_red,
    output logic [POS_W-1:0] pos_blue,
    output logic [POS_W-1:0] pos_yellow,
    output logic             winner_valid,
    output logic [1:0]       winner_id
);

    localparam int MAX_AB     = (COUNT_STEP_FRAMES > WIN_HOLD_FRAMES) ? COUNT_STEP_FRAMES : WIN_HOLD_FRAMES;
    localparam int MAX_FRAMES = (MAX_AB > PENALTY_FRAMES) ? MAX_AB : PENALTY_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES) + 1;

    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(COUNT_STEP_FRAMES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(WIN_HOLD_FRAMES - 1);

    phase_e           phase_q;
    logic [1:0]       countdown_q;
    logic             winner_valid_q;
    logic [1:0]       winner_id_q;
    logic [CNT_W-1:0] tick_cnt_q;
    logic             frame_prev_q;

    logic             tick;
    logic [3:0]       btns;
    logic [3:0]       press;
    logic [3:0]       finish;
    logic [POS_W-1:0] pos [4];
    logic             any_press;
    logic             clear_pos;
    logic             step_en;
    logic [1:0]       winner_d;

    assign tick      = update_frame & ~frame_prev_q;
    assign btns      = {btn_yellow, btn_blue, btn_red, btn_green};
    assign any_press = |press;
    assign clear_pos = (phase_q == PH_IDLE) && any_press;
    assign step_en   = (phase_q == PH_RACE);

`ifdef FALSE_START_PENALTY_EN
    logic lock_window;
    logic flag_set;
    logic flag_clr;

    // Lockout spans the first PENALTY_FRAMES ticks of RACE; the tick counter starts at 0 on entry.
    assign lock_window = (phase_q == PH_RACE) && (tick_cnt_q < CNT_W'(PENALTY_FRAMES));
    assign flag_set    = (phase_q == PH_COUNTDOWN);
    assign flag_clr    = (phase_q == PH_IDLE) || ((phase_q == PH_RACE) && !lock_window);
`endif

    for (genvar g = 0; g < 4; g++) begin : g_lane
        racer_lane #(
            .MAX_POS (MAX_POS),
            .POS_W   (POS_W)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .btn_i      (btns[g]),
            .clear_i    (clear_pos),
            .step_en_i  (step_en),
`ifdef FALSE_START_PENALTY_EN
            .flag_set_i (flag_set),
            .lock_i     (lock_window),
            .flag_clr_i (flag_clr),
`endif
            .press_o    (press[g]),
            .finish_o   (finish[g]),
            .pos_o      (pos[g])
        );
    end

    always_comb begin
        winner_d = YELLOW;
        if (finish[GREEN]) begin
            winner_d = GREEN;
        end else if (finish[RED]) begin
            winner_d = RED;
        end else if (finish[BLUE]) begin
            winner_d = BLUE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q        <= PH_IDLE;
            countdown_q    <= 2'd0;
            winner_valid_q <= 1'b0;
            winner_id_q    <= 2'd0;
            tick_cnt_q     <= '0;
            frame_prev_q   <= 1'b1;
        end else begin
            frame_prev_q <= update_frame;
            case (phase_q)
                PH_IDLE: begin
                    if (any_press) begin
                        phase_q     <= PH_COUNTDOWN;
                        countdown_q <= 2'd3;
                        tick_cnt_q  <= '0;
                    end
                end
                PH_COUNTDOWN: begin
                    if (tick) begin
                        if (tick_cnt_q == STEP_LAST) begin
                            tick_cnt_q <= '0;
                            if (countdown_q == 2'd1) begin
                                phase_q     <= PH_RACE;
                                countdown_q <= 2'd0;
                            end else begin
                                countdown_q <= countdown_q - 2'd1;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                end
                PH_RACE: begin
                    if (|finish) begin
                        phase_q        <= PH_WIN;
                        winner_valid_q <= 1'b1;
                        winner_id_q    <= winner_d;
                        tick_cnt_q     <= '0;
                    end else if (tick && (tick_cnt_q != '1)) begin
                        tick_cnt_q <= tick_cnt_q + 1'b1;
                    end
                end
                PH_WIN: begin
                    if (tick) begin
                        if (tick_cnt_q == HOLD_LAST) begin
                            phase_q        <= PH_IDLE;
                            winner_valid_q <= 1'b0;
                            tick_cnt_q     <= '0;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                end
                default: phase_q <= PH_IDLE;
            endcase
        end
    end

    assign phase        = phase_q;
    assign countdown    = countdown_q;
    assign winner_valid = winner_valid_q;
    assign winner_id    = winner_id_q;
    assign pos_green    = pos[GREEN];
    assign pos_red      = pos[RED];
    assign pos_blue     = pos[BLUE];
    assign pos_yellow   = pos[YELLOW];

endmodule

// File: tb/tb_race_sequencer.sv
// Directed bench for race_sequencer with small parameters (MAX_POS=8, steps of 2, hold 4, penalty 3).
// Define FALSE_START_PENALTY_EN on both bench and RTL to exercise the lockout.
module tb_race_sequencer;

    logic       clk;
    logic       rst_n;
    logic       update_frame;
    logic [3:0] btns;
    logic [1:0] phase;
    logic [1:0] countdown;
    logic [2:0] pos_green;
    logic [2:0] pos_red;
    logic [2:0] pos_blue;
    logic [2:0] pos_yellow;
    logic       winner_valid;
    logic [1:0] winner_id;

    int total;
    int bad;

    race_sequencer #(
        .MAX_POS           (8),
        .COUNT_STEP_FRAMES (2),
        .WIN_HOLD_FRAMES   (4),
        .PENALTY_FRAMES    (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .update_frame (update_frame),
        .btn_green    (btns[0]),
        .btn_red      (btns[1]),
        .btn_blue     (btns[2]),
        .btn_yellow   (btns[3]),
        .phase        (phase),
        .countdown    (countdown),
        .pos_green    (pos_green),
        .pos_red      (pos_red),
        .pos_blue     (pos_blue),
        .pos_yellow   (pos_yellow),
        .winner_valid (winner_valid),
        .winner_id    (winner_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance n clock edges, leaving time 1 unit past the last edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] mask);
        btns = btns | mask;
        cyc(1);
        btns = btns & ~mask;
        cyc(1);
    endtask

    task automatic press_n(input logic [3:0] mask, input int n);
        for (int i = 0; i < n; i++) press(mask);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            update_frame = 1'b1;
            cyc(1);
            update_frame = 1'b0;
            cyc(1);
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst_n        = 1'b0;
        update_frame = 1'b0;
        btns         = 4'b0010;
        cyc(3);
        check("rst_phase", phase, 0);
        check("rst_countdown", countdown, 0);
        check("rst_pos_green", pos_green, 0);
        check("rst_pos_red", pos_red, 0);
        check("rst_winner_valid", winner_valid, 0);
        check("rst_winner_id", winner_id, 0);

        rst_n = 1'b1;
        cyc(3);
        check("held_red_no_start", phase, 0);
        check("held_red_pos", pos_red, 0);
        btns = 4'b0000;
        cyc(1);
        press(4'b0010);
        check("start_phase", phase, 1);
        check("start_countdown", countdown, 3);

        tick(1);
        check("cd_one_tick", countdown, 3);
        tick(1);
        check("cd_digit2", countdown, 2);
        press(4'b0001);
        check("cd_green_press_dropped", pos_green, 0);
`ifdef FALSE_START_PENALTY_EN
        press(4'b1000);
`endif
        tick(2);
        check("cd_digit1", countdown, 1);
        check("cd_phase", phase, 1);
        tick(2);
        check("race_phase", phase, 2);
        check("race_countdown", countdown, 0);

`ifdef FALSE_START_PENALTY_EN
        press(4'b1000);
        check("pen_tick0", pos_yellow, 0);
        tick(1);
        press(4'b1000);
        check("pen_tick1", pos_yellow, 0);
        tick(1);
        press(4'b1000);
        check("pen_tick2", pos_yellow, 0);
        tick(1);
        press(4'b1000);
        check("pen_after_lockout", pos_yellow, 1);
`endif

        press_n(4'b0001, 3);
        check("green_3", pos_green, 3);
        btns = 4'b0001;
        cyc(50);
        btns = 4'b0000;
        cyc(1);
        check("green_held_once", pos_green, 4);
        press_n(4'b0001, 2);
        check("green_6", pos_green, 6);
        check("still_race", phase, 2);
        press(4'b0001);
        check("green_finish_pos", pos_green, 7);
        check("green_win_phase", phase, 3);
        check("green_winner_valid", winner_valid, 1);
        check("green_winner_id", winner_id, 0);
        press(4'b0011);
        check("win_green_frozen", pos_green, 7);
        check("win_red_frozen", pos_red, 0);

        tick(3);
        check("win_hold_3", phase, 3);
        tick(1);
        check("win_to_idle", phase, 0);
        check("idle_winner_valid", winner_valid, 0);
        check("idle_keeps_pos", pos_green, 7);

        press(4'b0100);
        check("restart_phase", phase, 1);
        check("restart_countdown", countdown, 3);
        check("restart_clear_green", pos_green, 0);
        check("restart_clear_blue", pos_blue, 0);
        tick(6);
        check("race2_phase", phase, 2);
        press_n(4'b0110, 6);
        check("tie_red_6", pos_red, 6);
        check("tie_blue_6", pos_blue, 6);
        check("tie_no_win_yet", phase, 2);
        press(4'b0110);
        check("tie_red_7", pos_red, 7);
        check("tie_blue_7", pos_blue, 7);
        check("tie_phase", phase, 3);
        check("tie_winner_id", winner_id, 1);

        tick(4);
        check("race3_idle", phase, 0);
        press(4'b0100);
        tick(6);
        check("race3_phase", phase, 2);
        press_n(4'b0100, 5);
        check("race3_blue_5", pos_blue, 5);
        rst_n = 1'b0;
        cyc(1);
        check("abort_phase", phase, 0);
        check("abort_pos_blue", pos_blue, 0);
        check("abort_winner_valid", winner_valid, 0);
        rst_n = 1'b1;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
